mux_rr_n_1: RTL and testbench
=============================

Name: mux_rr_n_1

Overview:
- Parametrised N:1 multiplexer with valid/ready handshake on every input channel and on the output.
- Two selection modes:
  - manual: a `sel` input picks the channel.
  - round-robin: an internal fair arbiter picks the channel.
- The selected word and its channel tag are held in a single output register.
- Sits between several producer streams and one shared consumer (bus, FIFO or serializer); it replaces the plain combinational 2:1 mux wherever channels must be merged without loss.

Parameters:
- NUM_CH, 4, number of input channels; must be >= 2.
- DATA_W, 8, width of each data word.
- SEL_W, $clog2(NUM_CH), width of `sel` and `out_ch`; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_data  input  NUM_CH*DATA_W  packed channel words; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- mode  input  1  0 = manual select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset: all state updates only on posedge clk. rst_n=0 on an edge forces:
  - out_valid=0, out_data=0, out_ch=0;
  - rr_ptr (last-granted index) = NUM_CH-1, so channel 0 has top priority after reset.
  - Reset mid-transfer discards the held word with no side effects.
- Output load condition: load_en = !out_valid || out_ready. This gives full throughput of one word per cycle.
- Channel choice, `chosen`, is combinational:
  - mode=0: chosen = sel, and a grant exists only if sel < NUM_CH and in_valid[sel]=1. Other channels' valids are ignored.
  - mode=1: chosen = the first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, … modulo NUM_CH (wrap NUM_CH-1 -> 0). There is no grant if all valids are 0.
- in_ready[i] = load_en && grant && (i == chosen). At most one bit of in_ready is high per cycle. in_ready never depends on in_valid[i] of the same channel except through grant.
- Transfer occurs when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= word i;
  - out_ch <= i;
  - out_valid <= 1;
  - if mode=1: rr_ptr <= i.
  - rr_ptr is unchanged by mode=0 grants.
- Output drain: when out_valid && out_ready and no new grant, out_valid <= 0 on the next edge. out_data and out_ch hold their last value.
- Stall: when out_valid=1 && out_ready=0:
  - in_ready = 0 for all channels;
  - out_data, out_ch and out_valid are held stable until accepted.
- Simultaneous drain and grant: the new word replaces the old one in the same edge, with no bubble.
- Latency: input word to out_valid is 1 cycle.
- Mode or sel change: takes effect in the same cycle's combinational choice. An already-held output word is unaffected.
- Out-of-range sel (NUM_CH not a power of two) with mode=0: no grant; all in_ready=0.
- No word is ever dropped or duplicated. Each accepted input produces exactly one output beat.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000 during reset. After release, the first round-robin grant goes to ch0.
- Manual mode: NUM_CH=4, DATA_W=8, mode=0, sel=2, in_data ch0..3 = 0x10,0x20,0x30,0x40, all valid, out_ready=1 -> in_ready=0100. Next cycle out_data=0x30, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Round-robin skip and wrap: mode=1, only ch1 and ch3 valid, rr_ptr=3 after reset-default scan -> grants alternate 1,3,1,3. in_ready[0] and in_ready[2] stay 0.
- Backpressure: out_ready=0 for 3 cycles while ch0 holds 0xAA -> out_data=0xAA stable, in_ready=0000. Raise out_ready -> 0xAA accepted once, next word loads in the same edge.
- Out-of-range sel: NUM_CH=3, mode=0, sel=3, all valid -> in_ready=000; out_valid drops to 0 after the pending word drains.

Source files
------------

// File: rtl/mux_rr_n_1.sv
// N:1 valid/ready mux with manual or round-robin channel choice; one registered output stage (1 cycle latency).
// Output stalls hold the word and deassert every in_ready; a drain and a new grant share one edge, so there are no bubbles.
module mux_rr_n_1 #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load_en;
  logic              grant;
  logic [SEL_W-1:0]  chosen;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] chosen_word;

  always_comb begin
    load_en = !out_valid_q || out_ready;
    grant   = 1'b0;
    chosen  = '0;
    idx     = '0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so it never grants.
      chosen = sel;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i)) grant = in_valid[i];
      end
    end else begin
      // Scan farthest offset first so the nearest valid after rr_ptr wins.
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = SEL_W'((int'(rr_ptr_q) + k) % NUM_CH);
        if (in_valid[idx]) begin
          chosen = idx;
          grant  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    chosen_word = '0;
    in_ready    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chosen == SEL_W'(i)) chosen_word = in_data[i*DATA_W +: DATA_W];
      in_ready[i] = rst_n && load_en && grant && (chosen == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (grant) begin
        out_data_d  = chosen_word;
        out_ch_d    = chosen;
        out_valid_d = 1'b1;
        if (mode) rr_ptr_d = chosen;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n_1.sv
// Bench for mux_rr_n_1: directed vectors on a 4-channel and a 3-channel instance,
// expected beats queued at issue time and popped by per-instance monitors.
module tb_mux_rr_n_1;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] dat;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic [31:0] d4  = {8'h40, 8'h30, 8'h20, 8'h10};
  logic [3:0]  v4  = '0;
  logic [3:0]  r4;
  logic        m4  = 1'b1;
  logic [1:0]  s4  = '0;
  logic [7:0]  od4;
  logic [1:0]  oc4;
  logic        ov4;
  logic        or4 = 1'b1;

  logic [23:0] d3  = {8'h33, 8'h22, 8'h11};
  logic [2:0]  v3  = '0;
  logic [2:0]  r3;
  logic        m3  = 1'b0;
  logic [1:0]  s3  = '0;
  logic [7:0]  od3;
  logic [1:0]  oc3;
  logic        ov3;
  logic        or3 = 1'b1;

  int errors = 0;
  int checks = 0;
  beat_t q4[$];
  beat_t q3[$];

  mux_rr_n_1 #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
    .mode(m4), .sel(s4), .out_data(od4), .out_ch(oc4), .out_valid(ov4), .out_ready(or4)
  );

  mux_rr_n_1 #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .mode(m3), .sel(s3), .out_data(od3), .out_ch(oc3), .out_valid(ov3), .out_ready(or3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle on the 4-channel instance: drive, check in_ready, queue the expected beat.
  task automatic step4(input logic rn, input logic md, input logic [1:0] sl, input logic [3:0] vl,
                       input logic ordy, input logic [3:0] exp_rdy, input string nm);
    @(posedge clk);
    #2;
    rst_n = rn; m4 = md; s4 = sl; v4 = vl; or4 = ordy;
    #1;
    chk(nm, 32'(r4), 32'(exp_rdy));
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) q4.push_back(beat_t'{ch: 2'(i), dat: d4[i*8 +: 8]});
  endtask

  task automatic step3(input logic [1:0] sl, input logic [2:0] vl, input logic [2:0] exp_rdy,
                       input string nm);
    @(posedge clk);
    #2;
    rst_n = 1'b1; m3 = 1'b0; s3 = sl; v3 = vl; or3 = 1'b1;
    #1;
    chk(nm, 32'(r3), 32'(exp_rdy));
    for (int i = 0; i < 3; i++)
      if (exp_rdy[i]) q3.push_back(beat_t'{ch: 2'(i), dat: d3[i*8 +: 8]});
  endtask

  // A beat is consumed at the next edge when valid and ready are both high at the negedge.
  always @(negedge clk) begin
    if (ov4 === 1'b1 && or4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb4_extra: got ch=%0d data=%0h, expected no beat", oc4, od4);
      end else begin
        beat_t e;
        e = q4.pop_front();
        chk("sb4_beat", {22'd0, oc4, od4}, {22'd0, e.ch, e.dat});
      end
    end
  end

  always @(negedge clk) begin
    if (ov3 === 1'b1 && or3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb3_extra: got ch=%0d data=%0h, expected no beat", oc3, od3);
      end else begin
        beat_t e;
        e = q3.pop_front();
        chk("sb3_beat", {22'd0, oc3, od3}, {22'd0, e.ch, e.dat});
      end
    end
  end

  initial begin
    // Reset with every channel valid: nothing may be granted.
    step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, "rst_rdy0");
    step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, "rst_rdy1");
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_out_data",  32'(od4), 32'd0);
    chk("rst_out_ch",    32'(oc4), 32'd0);

    // Round-robin, all channels valid: 0,1,2,3,0,1 back to back.
    step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_g0");
    step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr_g1");
    chk("rr_no_bubble", 32'(ov4), 32'd1);
    step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "rr_g2");
    step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, "rr_g3");
    step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_g4");
    step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr_g5");

    // Manual select of channel 2.
    step4(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, "man_sel2");
    // Reset again (rr_ptr back to 3) while the manual word is consumed.
    step4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "rst2_rdy");
    chk("man_out_data",  32'(od4), 32'h30);
    chk("man_out_ch",    32'(oc4), 32'd2);
    chk("man_out_valid", 32'(ov4), 32'd1);

    // Only ch1 and ch3 valid: grants alternate, ch0/ch2 never ready.
    step4(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, "skip_g1a");
    step4(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, "skip_g3a");
    step4(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, "skip_g1b");
    step4(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, "skip_g3b");

    // Backpressure on a held 0xAA from ch0.
    d4[7:0] = 8'hAA;
    step4(1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, "bp_load");
    for (int c = 0; c < 3; c++) begin
      step4(1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, "bp_stall_rdy");
      chk("bp_hold_data",  32'(od4), 32'hAA);
      chk("bp_hold_valid", 32'(ov4), 32'd1);
    end
    d4[7:0] = 8'hBB;
    step4(1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, "bp_release");
    chk("bp_still_aa", 32'(od4), 32'hAA);
    step4(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "drain_rdy");
    chk("bp_next_word", 32'(od4), 32'hBB);
    step4(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "idle_rdy");
    chk("drain_valid", 32'(ov4), 32'd0);
    chk("drain_hold_data", 32'(od4), 32'hBB);

    // Three channels: sel=3 is out of range and never grants.
    step3(2'd1, 3'b111, 3'b010, "n3_sel1");
    step3(2'd3, 3'b111, 3'b000, "n3_oor_a");
    chk("n3_pending_valid", 32'(ov3), 32'd1);
    chk("n3_pending_ch",    32'(oc3), 32'd1);
    step3(2'd3, 3'b111, 3'b000, "n3_oor_b");
    chk("n3_drained", 32'(ov3), 32'd0);
    step3(2'd3, 3'b111, 3'b000, "n3_oor_c");
    chk("n3_stay_idle", 32'(ov3), 32'd0);

    @(posedge clk);
    #3;
    chk("sb4_empty", 32'(q4.size()), 32'd0);
    chk("sb3_empty", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
